// File: rtl/uart_fifo_arb_pkg.sv
// rtl/uart_fifo_arb_pkg.sv - shared types and width helpers for the UART-to-FIFO write arbiter
// Contents:
//   state_t      - arbiter FSM states (ST_PAD is reached only when UART_FIFO_ARB_PAD_EN is defined)
//   cnt_width    - bits needed to index n items, never less than 1
//   beat_width   - beat counter width for a given BEATS
//   stall_width  - stall counter width able to hold the value TIMEOUT
package uart_fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  function automatic int cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int beat_width(input int unsigned beats);
    return cnt_width(beats);
  endfunction

  function automatic int stall_width(input int unsigned timeout);
    return cnt_width(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Ports:
//   req        in  N      request vector
//   last_grant in  IDX_W  index of the most recently served requester
//   grant      out N      one-hot pick, first set req bit searching upward from last_grant+1
//                         (wrapping); all zero when req is zero
module rr_arbiter
  import uart_fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = cnt_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // Offset 1..N from the last winner, so the last winner itself is checked last.
    for (int i = 1; i <= N; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_arbiter.sv
// rtl/uart_fifo_arbiter.sv - round-robin arbiter feeding BEATS-word bursts into the FIFO write port
// Build option: UART_FIFO_ARB_PAD_EN adds a stall counter and the PAD state, which fills a
// stalled partial word with PAD_VALUE after TIMEOUT idle LOCK cycles.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   req_valid_i   per-requester valid            req_data_i   packed requester words
//   req_ready_o   per-requester accept           fifo_data_o  word to FIFO
//   fifo_valid_o  FIFO write valid               fifo_ready_i FIFO write ready
//   grant_o       one-hot owner, 0 when idle     busy_o       not in IDLE
//   pad_event_o   one-cycle pulse on PAD entry
module uart_fifo_arbiter
  import uart_fifo_arb_pkg::*;
#(
  parameter int          NUM_REQ    = 4,
  parameter int          DATA_WIDTH = 8,
  parameter int          BEATS      = 4,
  parameter int          TIMEOUT    = 1023,
  parameter int unsigned PAD_VALUE  = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_valid_o,
  input  logic                          fifo_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          pad_event_o
);

  localparam int IDX_W  = cnt_width(NUM_REQ);
  localparam int BEAT_W = beat_width(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0 ||
      TIMEOUT < 1 || (PAD_VALUE >> DATA_WIDTH) != 0) begin : g_bad_cfg
    $error("uart_fifo_arbiter: unsupported parameter set");
  end

  state_t              state;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    last_grant;
  logic [BEAT_W-1:0]   beat;
  logic [NUM_REQ-1:0]  pick;
  logic [IDX_W-1:0]    pick_idx;
  logic                hs;
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_word[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) pick_idx = IDX_W'(k);
    end
  end

  // Pass-through: the FIFO sees the owner directly so a beat can land in the first LOCK cycle.
  always_comb begin
    fifo_valid_o = 1'b0;
    fifo_data_o  = '0;
    req_ready_o  = '0;
    if (state == ST_LOCK) begin
      fifo_valid_o       = req_valid_i[owner];
      fifo_data_o        = req_word[owner];
      req_ready_o[owner] = fifo_ready_i;
    end
`ifdef UART_FIFO_ARB_PAD_EN
    else if (state == ST_PAD) begin
      fifo_valid_o = 1'b1;
      fifo_data_o  = DATA_WIDTH'(PAD_VALUE);
    end
`endif
  end

  assign hs     = fifo_valid_o & fifo_ready_i;
  assign busy_o = (state != ST_IDLE);

`ifdef UART_FIFO_ARB_PAD_EN
  localparam int STALL_W = stall_width(TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  logic [STALL_W-1:0] stall;
  logic               pad_event_q;
  assign pad_event_o = pad_event_q;
`else
  assign pad_event_o = 1'b0;
`endif

  // BEATS is a power of two, so beat + 1 wraps to 0 on the last beat by itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant_o    <= '0;
      owner      <= '0;
      beat       <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
`ifdef UART_FIFO_ARB_PAD_EN
      stall       <= '0;
      pad_event_q <= 1'b0;
`endif
    end else begin
`ifdef UART_FIFO_ARB_PAD_EN
      pad_event_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (|req_valid_i) begin
            state   <= ST_LOCK;
            grant_o <= pick;
            owner   <= pick_idx;
            beat    <= '0;
`ifdef UART_FIFO_ARB_PAD_EN
            stall   <= '0;
`endif
          end
        end
        ST_LOCK: begin
          if (hs) begin
`ifdef UART_FIFO_ARB_PAD_EN
            stall <= '0;
`endif
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state      <= ST_IDLE;
              grant_o    <= '0;
              last_grant <= owner;
            end
          end
`ifdef UART_FIFO_ARB_PAD_EN
          else if (stall == STALL_LAST) begin
            stall <= '0;
            if (beat != '0) begin
              state       <= ST_PAD;
              pad_event_q <= 1'b1;
            end else begin
              // Nothing was written yet: give up the lock without charging this requester a turn.
              state   <= ST_IDLE;
              grant_o <= '0;
            end
          end else begin
            stall <= stall + 1'b1;
          end
`endif
        end
`ifdef UART_FIFO_ARB_PAD_EN
        ST_PAD: begin
          if (fifo_ready_i) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state      <= ST_IDLE;
              grant_o    <= '0;
              last_grant <= owner;
            end
          end
        end
`endif
        default: begin
          state   <= ST_IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_arbiter.sv
// tb/tb_uart_fifo_arbiter.sv - self-checking bench for uart_fifo_arbiter
module tb_uart_fifo_arbiter;
  localparam int NUM = 4;
  localparam int DW = 8;
  localparam int BEATS = 4;
  localparam int TIMEOUT = 8;
  localparam logic [7:0] PADV = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NUM-1:0]    req_valid_i;
  logic [NUM*DW-1:0] req_data_i;
  logic [NUM-1:0]    req_ready_o;
  logic [DW-1:0]     fifo_data_o;
  logic              fifo_valid_o;
  logic              fifo_ready_i;
  logic [NUM-1:0]    grant_o;
  logic              busy_o;
  logic              pad_event_o;

  uart_fifo_arbiter #(
    .NUM_REQ(NUM), .DATA_WIDTH(DW), .BEATS(BEATS), .TIMEOUT(TIMEOUT), .PAD_VALUE(PADV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .fifo_data_o(fifo_data_o), .fifo_valid_o(fifo_valid_o),
    .fifo_ready_i(fifo_ready_i), .grant_o(grant_o), .busy_o(busy_o), .pad_event_o(pad_event_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: what each requester offered, and how far the FIFO has consumed it.
  logic [7:0] src [NUM][$];
  logic [7:0] orig [NUM][$];
  int pos [NUM];
  bit en [NUM];
  bit rnd, force_go, rdy_hold;
  int wcount, model_last, cyc, writes, quiet, pad_events, first_cyc, last_cyc, pick_cyc;
  bit expect_pick, idle_due, pad_seen;
  logic [NUM-1:0] exp_grant;
  int owners[$];

  function automatic int rr_pick(input int last, input logic [NUM-1:0] v);
    for (int i = 1; i <= NUM; i++) begin
      int k;
      k = (last + i) % NUM;
      if (v[k]) return k;
    end
    return 0;
  endfunction

  task automatic load(input int k, input int nwords);
    for (int i = 0; i < nwords * BEATS; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      src[k].push_back(v);
      orig[k].push_back(v);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NUM; k++) begin
      req_valid_i[k] = en[k] && src[k].size() > 0 &&
                       (!rnd || force_go || $urandom_range(0, 3) != 0);
      req_data_i[k*DW +: DW] = (src[k].size() > 0) ? src[k][0] : 8'h00;
    end
    fifo_ready_i = rnd ? (force_go || $urandom_range(0, 3) != 0) : rdy_hold;
  endtask

  task automatic monitor();
    int g;
    logic [NUM-1:0] exp_rdy;
    logic [7:0] exp_d;
    if (pad_event_o) begin
      pad_seen = 1'b1;
      pad_events++;
    end
    if (expect_pick) begin
      check("arb_pick", 32'(grant_o), 32'(exp_grant));
      expect_pick = 1'b0;
    end
    if (idle_due) begin
      check("bubble", 32'({grant_o, busy_o}), 32'd0);
      idle_due = 1'b0;
    end
    g = -1;
    for (int k = 0; k < NUM; k++) if (grant_o[k]) g = k;
    for (int k = 0; k < NUM; k++) exp_rdy[k] = grant_o[k] && fifo_ready_i && !pad_seen;
    check("ready", 32'(req_ready_o), 32'(exp_rdy));
    if (!busy_o) check("idle_out", 32'({fifo_valid_o, fifo_data_o, grant_o}), 32'd0);
    else if (g >= 0) check("valid_pass", 32'(fifo_valid_o), 32'(pad_seen ? 1'b1 : req_valid_i[g]));
    if (fifo_valid_o && fifo_ready_i) begin
      check("owner_onehot", 32'($onehot(grant_o)), 32'd1);
      if (g >= 0) begin
        exp_d = (pos[g] < orig[g].size()) ? orig[g][pos[g]] : PADV;
        check("wdata", 32'(fifo_data_o), 32'(exp_d));
        if (pos[g] < orig[g].size()) pos[g]++;
        if (wcount == 0) begin
          owners.push_back(g);
          first_cyc = cyc;
        end
        wcount++;
        writes++;
        last_cyc = cyc;
        if (wcount == BEATS) begin
          wcount = 0;
          model_last = g;
          idle_due = 1'b1;
          pad_seen = 1'b0;
        end
      end
      quiet = 0;
    end else if (busy_o) quiet++;
    else quiet = 0;
    if (!busy_o && |req_valid_i) begin
      exp_grant = '0;
      exp_grant[rr_pick(model_last, req_valid_i)] = 1'b1;
      expect_pick = 1'b1;
      pick_cyc = cyc;
    end
    force_go = rnd && quiet >= 3;
  endtask

  task automatic step();
    logic [NUM-1:0] acc;
    @(negedge clk);
    cyc++;
    acc = rst_n ? (req_valid_i & req_ready_o) : '0;
    if (rst_n) monitor();
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM; k++) if (acc[k]) void'(src[k].pop_front());
    drive();
  endtask

  function automatic bit done();
    for (int k = 0; k < NUM; k++) if (src[k].size() != 0) return 1'b0;
    return wcount == 0 && !busy_o;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!done() && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(done()), 32'd1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (wcount != target && n < budget) begin
      step();
      n++;
    end
    check("wait_beats", 32'(wcount), 32'(target));
  endtask

  task automatic check_quiet_outputs(input string tag);
    check(tag, 32'({grant_o, busy_o, fifo_valid_o, req_ready_o, pad_event_o}), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst_n = 1'b0;
    req_valid_i = '0;
    req_data_i = '0;
    fifo_ready_i = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      en[k] = 1'b1;
      pos[k] = 0;
    end
    rnd = 0; force_go = 0; rdy_hold = 1'b1;
    wcount = 0; model_last = NUM - 1; cyc = 0; writes = 0; quiet = 0; pad_events = 0;
    expect_pick = 0; idle_due = 0; pad_seen = 0;
    step();
    step();
    check_quiet_outputs("reset_state");
    rst_n = 1'b1;
    step();

    // Contention: every requester has two words ready.
    owners.delete();
    for (int k = 0; k < NUM; k++) load(k, 2);
    drive();
    drain("contention_done", 200);
    check("rr_count", 32'(owners.size()), 32'd8);
    for (int i = 0; i < owners.size() && i < 8; i++) check("rr_order", 32'(owners[i]), 32'(i % NUM));

    // Single requester, fixed bytes.
    src[2].push_back(8'h11); src[2].push_back(8'h22); src[2].push_back(8'h33); src[2].push_back(8'h44);
    orig[2].push_back(8'h11); orig[2].push_back(8'h22); orig[2].push_back(8'h33); orig[2].push_back(8'h44);
    drive();
    drain("single_done", 50);
    check("single_span", 32'(last_cyc - first_cyc), 32'd3);
    check("single_latency", 32'(first_cyc - pick_cyc), 32'd1);

    // Backpressure after the second beat.
    w0 = writes;
    load(1, 1);
    drive();
    wait_beats(2, 20);
    rdy_hold = 1'b0;
    drive();
    repeat (3) begin
      step();
      check("bp_data", 32'(fifo_data_o), 32'(orig[1][pos[1]]));
      check("bp_valid", 32'(fifo_valid_o), 32'd1);
      check("bp_beat", 32'(wcount), 32'd2);
    end
    rdy_hold = 1'b1;
    drive();
    drain("bp_done", 50);
    check("bp_writes", 32'(writes - w0), 32'(BEATS));

`ifndef UART_FIFO_ARB_PAD_EN
    // Owner stalls mid-word; the lock must survive and others stay blocked.
    en[3] = 1'b0;
    load(0, 1);
    load(3, 1);
    drive();
    wait_beats(2, 20);
    en[0] = 1'b0;
    en[3] = 1'b1;
    drive();
    repeat (100) step();
    check("stall_grant", 32'(grant_o), 32'b0001);
    check("stall_beat", 32'(wcount), 32'd2);
    en[0] = 1'b1;
    drive();
    drain("stall_done", 50);
    check("stall_next", 32'(owners[owners.size()-1]), 32'd3);
`else
    // Owner supplies only two beats; the rest of the word must be padding.
    w0 = writes;
    for (int i = 0; i < 2; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      src[0].push_back(v);
      orig[0].push_back(v);
    end
    drive();
    wait_beats(2, 20);
    begin
      int n;
      n = 0;
      while (!pad_event_o && n < 30) begin
        step();
        n++;
      end
      check("pad_delay", 32'(n), 32'(TIMEOUT));
    end
    drain("pad_done", 20);
    check("pad_events", 32'(pad_events), 32'd1);
    check("pad_writes", 32'(writes - w0), 32'(BEATS));
    check("pad_owner", 32'(owners[owners.size()-1]), 32'd0);
`endif

    // Randomized valid/ready traffic.
    rnd = 1'b1;
    repeat (4) begin
      for (int k = 0; k < NUM; k++) load(k, int'($urandom_range(1, 3)));
      drive();
      drain("random_done", 1500);
    end
    rnd = 1'b0;
    force_go = 1'b0;
    drive();
    for (int k = 0; k < NUM; k++) check("complete", 32'(pos[k]), 32'(orig[k].size()));

    // Reset in the middle of a word.
    load(1, 1);
    drive();
    wait_beats(2, 20);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < NUM; k++) begin
      src[k].delete();
      orig[k].delete();
      pos[k] = 0;
    end
    wcount = 0; model_last = NUM - 1; expect_pick = 0; idle_due = 0; pad_seen = 0; quiet = 0;
    drive();
    check_quiet_outputs("midword_reset");
    owners.delete();
    load(1, 1);
    load(3, 1);
    drive();
    drain("post_reset_done", 50);
    check("post_reset_count", 32'(owners.size()), 32'd2);
    if (owners.size() >= 2) begin
      check("post_reset_first", 32'(owners[0]), 32'd1);
      check("post_reset_second", 32'(owners[1]), 32'd3);
    end

    step();
    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_fifo_arbiter.md
# uart_fifo_arbiter

Round-robin arbiter that multiplexes NUM_REQ byte-wide producers (UART RX channels, debug injectors) onto the single write port of the shared width-converting FIFO. Grant is held for exactly BEATS accepted writes, so each FIFO output word is built from one requester only and never interleaved. It sits between the UART receive channels and the FIFO write side and does not touch the FIFO read side.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, requester/FIFO input word width
- BEATS, 4, input words per FIFO output word; power of 2, equals the FIFO's OUT/IN width ratio
- TIMEOUT, 1023, stall cycles before a locked word is padded (padding build only)
- PAD_VALUE, 8'h00, padding word value
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester data valid
- req_data_i  in  NUM_REQ*DATA_WIDTH  requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_ready_o  out  NUM_REQ  per-requester accept
- fifo_data_o  out  DATA_WIDTH  to FIFO data_i
- fifo_valid_o  out  1  to FIFO write_valid_i
- fifo_ready_i  in  1  from FIFO write_ready_o
- grant_o  out  NUM_REQ  one-hot current owner, 0 when idle
- busy_o  out  1  high in any state except IDLE
- pad_event_o  out  1  one-cycle pulse when padding starts

## Operation
- States: IDLE, LOCK, PAD (PAD exists only in the padding build).
- IDLE: all outputs 0. If any req_valid_i is set, pick the first set bit searching upward (wrapping) from last_grant+1. Register the grant, clear beat counter, go to LOCK.
- LOCK: combinational pass-through for owner g: fifo_valid_o=req_valid_i[g], fifo_data_o=req_data_i[g], req_ready_o[g]=fifo_ready_i. All other req_ready_o are 0.
- A write handshake (fifo_valid_o & fifo_ready_i) increments beat, width $clog2(BEATS). A handshake at beat==BEATS-1 sets last_grant=g, wraps beat to 0, and goes to IDLE.
- Non-owners are held off. The owner may drop valid mid-word, and the grant is kept.
- fifo_ready_i may fall at any time, for example while the FIFO is full or doing a read handshake. The arbiter holds data and count; no beat is lost or duplicated.
- Reset: state IDLE, beat 0, stall counter 0, last_grant NUM_REQ-1 (so requester 0 has first priority). All outputs 0. Reset mid-word drops the partial word; the FIFO shares rst_n and clears with it.

## Timing
- Arbitration latency is 1 cycle: the first valid request in IDLE produces grant_o in the next cycle.
- The first beat can be accepted in the first LOCK cycle.
- One IDLE bubble follows every word. Peak throughput is BEATS writes per BEATS+1 cycles.
- pass-through outputs are combinational from req_*_i and fifo_ready_i. Grant, beat and state are registered.
- Simultaneous requests are served in round-robin order. Every active requester gets at most one word before any other requester gets a second.

## Configuration
- UART_FIFO_ARB_PAD_EN defined: a stall counter of width $clog2(TIMEOUT+1) counts LOCK cycles without a handshake and clears on every handshake.
  - If the counter reaches TIMEOUT with beat>0: pulse pad_event_o, enter PAD. In PAD, fifo_valid_o=1, fifo_data_o=PAD_VALUE, and all req_ready_o are 0. Stay in PAD until beat wraps, then go to IDLE and update last_grant.
  - If the counter reaches TIMEOUT with beat==0: release to IDLE without padding and without updating last_grant.
- Not defined: no PAD state and no stall counter. pad_event_o is tied to 0. Lock is held indefinitely until BEATS handshakes complete.

## Structure
- uart_fifo_arb_pkg holds the state enum and helper localparams (beat and stall counter widths).
- Sub-module rr_arbiter: combinational round-robin picker with inputs req and last_grant, output one-hot grant. It is instantiated once.

## Test plan
- Single requester: req 2 sends 8'h11,22,33,44 with fifo_ready_i=1. Expect grant_o=4'b0100 one cycle after valid, four consecutive writes, then IDLE for 1 cycle.
- Contention: all 4 requesters continuously valid. Expect grant order 0,1,2,3,0, each grant lasting exactly 4 handshakes, with no interleaved beats.
- Backpressure: fifo_ready_i toggles low for 3 cycles after beat 1. Expect beat to hold, data stable, and exactly 4 writes total.
- Mid-word stall, padding build, TIMEOUT=8: owner stops after 2 beats. After 8 cycles expect pad_event_o pulse, then two 8'h00 writes, then IDLE.
- Same stall without UART_FIFO_ARB_PAD_EN: the grant is held for 100 cycles, other requesters see ready=0, and the word completes when the owner resumes.
- Reset after beat 2: rst_n low for 1 cycle. Expect all outputs 0 and a following request from 1 and 3 granting 1 first.
